uart_rx_sampler: RTL and testbench

//   Oversampling UART receive front end feeding the UART-to-Wishbone bridge command/address/data byte parser.

---
 rtl/uart_rx_sampler_if.sv | 12 +
 rtl/uart_rx_sampler.sv | 105 ++++++++++
 tb/tb_uart_rx_sampler.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/uart_rx_sampler_if.sv
// uart_rx_sampler_if: RX pin, enable and received-byte strobes of the UART receive front end
// master drives i_rx/i_start_rx and observes the byte outputs; slave is the receiver.
interface uart_rx_sampler_if;
  logic       i_rx;
  logic       i_start_rx;
  logic [7:0] o_data;
  logic       o_data_valid;
  logic       o_frame_err;
  logic       o_busy;
  modport master(output i_rx, i_start_rx, input o_data, o_data_valid, o_frame_err, o_busy);
  modport slave(input i_rx, i_start_rx, output o_data, o_data_valid, o_frame_err, o_busy);
endinterface

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: oversampling 8N1 UART receiver with 2-FF sync, start validation and 3-sample majority vote
// clk, rst (async, active-high); bus.i_rx line, bus.i_start_rx enable;
// bus.o_data last good byte, bus.o_data_valid / bus.o_frame_err 1-cycle strobes, bus.o_busy frame in progress.
module uart_rx_sampler #(
  parameter int BAUD_RATE  = 9600,
  parameter int CLOCK_FREQ = 50000000,
  parameter int OVERSAMPLE = 16
) (
  input logic              clk,
  input logic              rst,
  uart_rx_sampler_if.slave bus
);
  localparam int DIV = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int M   = OVERSAMPLE / 2;
  localparam int PW  = DIV > 1 ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  state_t          state_q, state_d;
  logic            meta_q, meta_d, rxs_q, rxs_d, rxp_q, rxp_d;
  logic [PW-1:0]   pc_q, pc_d;
  logic [SW-1:0]   sc_q, sc_d;
  logic [2:0]      idx_q, idx_d;
  logic [1:0]      smp_q, smp_d;
  logic [7:0]      shift_q, shift_d, data_q, data_d;
  logic            valid_q, valid_d, ferr_q, ferr_d;
  logic            tick, dec, vote, clr;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      meta_q  <= 1'b1;
      rxs_q   <= 1'b1;
      rxp_q   <= 1'b1;
      state_q <= IDLE;
      pc_q    <= '0;
      sc_q    <= '0;
      idx_q   <= '0;
      smp_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      meta_q  <= meta_d;
      rxs_q   <= rxs_d;
      rxp_q   <= rxp_d;
      state_q <= state_d;
      pc_q    <= pc_d;
      sc_q    <= sc_d;
      idx_q   <= idx_d;
      smp_q   <= smp_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  always_comb begin
    meta_d  = bus.i_rx;
    rxs_d   = meta_q;
    rxp_d   = rxs_q;
    tick    = state_q != IDLE && pc_q == PW'(DIV - 1);
    dec     = tick && sc_q == SW'(M + 1);
    // third vote sample is the live line at the decision tick
    vote    = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs_q) | (smp_q[1] & rxs_q);
    smp_d   = {tick && sc_q == SW'(M) ? rxs_q : smp_q[1], tick && sc_q == SW'(M - 1) ? rxs_q : smp_q[0]};
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE:  state_d = bus.i_start_rx && rxp_q && !rxs_q ? START : IDLE;
      START: if (dec) begin
        state_d = vote ? IDLE : DATA;
        idx_d   = '0;
      end
      DATA:  if (dec) begin
        shift_d[idx_q] = vote;
        idx_d          = idx_q + 3'd1;
        state_d        = idx_q == 3'd7 ? STOP : DATA;
      end
      STOP:  if (dec) begin
        state_d = vote ? IDLE : BRK;
        data_d  = vote ? shift_q : data_q;
        valid_d = vote;
        ferr_d  = !vote;
      end
      BRK:     state_d = rxs_q ? IDLE : BRK;
      default: state_d = IDLE;
    endcase
    if (!bus.i_start_rx) begin
      state_d = IDLE;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
    end
    // counters sit at zero in IDLE so the tick phase starts at the detected edge
    clr  = state_q == IDLE || state_d == IDLE;
    pc_d = clr || tick ? '0 : pc_q + 1'b1;
    sc_d = clr ? '0 : tick ? (sc_q == SW'(OVERSAMPLE - 1) ? '0 : sc_q + 1'b1) : sc_q;
  end
  assign bus.o_data       = data_q;
  assign bus.o_data_valid = valid_q;
  assign bus.o_frame_err  = ferr_q;
  assign bus.o_busy       = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb_uart_rx_sampler: directed frames against a byte-level expectation queue for uart_rx_sampler
module tb_uart_rx_sampler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  uart_rx_sampler_if bus();
  uart_rx_sampler #(.BAUD_RATE(100000), .CLOCK_FREQ(3200000), .OVERSAMPLE(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  int         checks = 0;
  int         fails = 0;
  int         n_valid = 0;
  int         n_ferr = 0;
  bit         saw_busy = 1'b0;
  bit         prev_strobe = 1'b0;
  logic [8:0] exp_q[$];
  logic [8:0] e;
  logic [7:0] model_data = 8'h00;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask
  always @(negedge clk)
    if (rst) begin
      model_data  = 8'h00;
      prev_strobe = 1'b0;
    end else begin
      if (bus.o_busy) saw_busy = 1'b1;
      if (bus.o_data_valid || bus.o_frame_err) begin
        check("exclusive strobes", 32'(bus.o_data_valid & bus.o_frame_err), 32'd0);
        check("strobe width", 32'(prev_strobe), 32'd0);
        if (bus.o_data_valid) n_valid++;
        if (bus.o_frame_err) n_ferr++;
        if (exp_q.size() == 0) check("unexpected strobe", 32'(exp_q.size()), 32'd1);
        else begin
          e = exp_q.pop_front();
          check("strobe kind/data", 32'({bus.o_frame_err, bus.o_frame_err ? 8'h00 : bus.o_data}), 32'(e));
          if (!e[8]) model_data = e[7:0];
        end
      end
      prev_strobe = bus.o_data_valid | bus.o_frame_err;
      check("o_data hold", 32'(bus.o_data), 32'(model_data));
    end
  task automatic bit_t(input logic v, input bit g);
    bus.i_rx = v;
    repeat (16) @(negedge clk);
    if (g) bus.i_rx = ~v;
    @(negedge clk);
    bus.i_rx = v;
    repeat (15) @(negedge clk);
  endtask
  task automatic send(input logic [7:0] b, input logic stop, input int gbit);
    bit_t(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) bit_t(b[i], i == gbit);
    bit_t(stop, 1'b0);
  endtask
  task automatic idle(input int n);
    bus.i_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    bus.i_rx = 1'b1;
    bus.i_start_rx = 1'b1;
    repeat (3) @(negedge clk);
    check("reset o_data", 32'(bus.o_data), 32'h0);
    check("reset o_data_valid", 32'(bus.o_data_valid), 32'h0);
    check("reset o_frame_err", 32'(bus.o_frame_err), 32'h0);
    check("reset o_busy", 32'(bus.o_busy), 32'h0);
    rst = 1'b0;
    idle(40);
    exp_q.push_back({1'b0, 8'hAA});
    exp_q.push_back({1'b0, 8'h55});
    send(8'hAA, 1'b1, -1);
    send(8'h55, 1'b1, -1);
    idle(40);
    check("t1 drained", 32'(exp_q.size()), 32'd0);
    check("t1 o_data", 32'(bus.o_data), 32'h55);
    check("t1 valid count", 32'(n_valid), 32'd2);
    check("t1 ferr count", 32'(n_ferr), 32'd0);
    saw_busy = 1'b0;
    bus.i_rx = 1'b0;
    repeat (10) @(negedge clk);
    idle(60);
    check("t2 busy pulsed", 32'(saw_busy), 32'd1);
    check("t2 busy idle", 32'(bus.o_busy), 32'd0);
    check("t2 valid count", 32'(n_valid), 32'd2);
    exp_q.push_back({1'b1, 8'h00});
    exp_q.push_back({1'b0, 8'h77});
    send(8'h3C, 1'b0, -1);
    bus.i_rx = 1'b0;
    repeat (96) @(negedge clk);
    idle(64);
    check("t3 ferr count", 32'(n_ferr), 32'd1);
    check("t3 o_data kept", 32'(bus.o_data), 32'h55);
    send(8'h77, 1'b1, -1);
    idle(40);
    check("t3 drained", 32'(exp_q.size()), 32'd0);
    check("t3 o_data", 32'(bus.o_data), 32'h77);
    exp_q.push_back({1'b0, 8'h00});
    send(8'h00, 1'b1, 2);
    idle(40);
    check("t4 drained", 32'(exp_q.size()), 32'd0);
    check("t4 o_data", 32'(bus.o_data), 32'h00);
    check("t4 valid count", 32'(n_valid), 32'd4);
    bus.i_start_rx = 1'b0;
    send(8'h77, 1'b1, -1);
    idle(40);
    check("t5 disabled no strobe", 32'(n_valid + n_ferr), 32'd5);
    check("t5 disabled busy", 32'(bus.o_busy), 32'd0);
    bus.i_start_rx = 1'b1;
    idle(32);
    bit_t(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) bit_t(1'b1, 1'b0);
    bus.i_rx = 1'b0;
    repeat (16) @(negedge clk);
    check("t5 busy mid-frame", 32'(bus.o_busy), 32'd1);
    bus.i_start_rx = 1'b0;
    @(posedge clk);
    #1;
    check("t5 busy after drop", 32'(bus.o_busy), 32'd0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) bit_t(i[0], 1'b0);
    idle(64);
    bus.i_start_rx = 1'b1;
    idle(32);
    check("t5 aborted no strobe", 32'(n_valid + n_ferr), 32'd5);
    exp_q.push_back({1'b0, 8'hA5});
    send(8'hA5, 1'b1, -1);
    idle(40);
    check("t5 drained", 32'(exp_q.size()), 32'd0);
    check("t5 o_data", 32'(bus.o_data), 32'hA5);
    bit_t(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) bit_t(1'b1, 1'b0);
    repeat (10) @(negedge clk);
    check("t6 busy before rst", 32'(bus.o_busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t6 rst o_data", 32'(bus.o_data), 32'h0);
    check("t6 rst o_busy", 32'(bus.o_busy), 32'h0);
    check("t6 rst strobes", 32'({bus.o_data_valid, bus.o_frame_err}), 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(64);
    exp_q.push_back({1'b0, 8'h12});
    send(8'h12, 1'b1, -1);
    idle(40);
    check("t6 drained", 32'(exp_q.size()), 32'd0);
    check("t6 o_data", 32'(bus.o_data), 32'h12);
    check("final valid count", 32'(n_valid), 32'd6);
    check("final ferr count", 32'(n_ferr), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
